// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one SPI master between two burst requesters
module spi_master_arbiter #(
    parameter int ADDR_W = 1,
    parameter int LEN_W  = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [1:0]          REQ,
    input  logic [2*ADDR_W-1:0] ADDR_IN,
    input  logic [2*LEN_W-1:0]  LEN_IN,
    output logic [1:0]          GNT,
    input  logic [15:0]         TX_DATA,
    input  logic [1:0]          TX_VLD,
    output logic [1:0]          TX_RDY,
    output logic [7:0]          RX_DATA,
    output logic [1:0]          RX_VLD,
    output logic [1:0]          DONE,
    output logic                BUSY,
    output logic [ADDR_W-1:0]   M_ADDR,
    output logic [7:0]          M_DIN,
    output logic                M_DIN_LAST,
    output logic                M_DIN_VLD,
    input  logic                M_READY,
    input  logic [7:0]          M_DOUT,
    input  logic                M_DOUT_VLD
);
    typedef enum logic [1:0] {IDLE, XFER, DRAIN, FIN} state_e;
    state_e            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d, done_q, done_d;
    logic              g_q, g_d, last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d, tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic              win, xfer, rx_on, tx_acc, tx_last, rx_last;

    always_comb begin
        win        = (&REQ) ? ~last_q : REQ[1];
        xfer       = state_q == XFER;
        rx_on      = xfer | state_q == DRAIN;
        tx_last    = tx_cnt_q == len_q;
        rx_last    = M_DOUT_VLD && rx_cnt_q == len_q;
        M_DIN      = xfer ? (g_q ? TX_DATA[15:8] : TX_DATA[7:0]) : 8'h00;
        M_DIN_VLD  = xfer & TX_VLD[g_q];
        M_DIN_LAST = xfer & tx_last;
        tx_acc     = M_DIN_VLD & M_READY;
        TX_RDY     = {2{xfer & M_READY}} & gnt_q;
        RX_VLD     = {2{rx_on & M_DOUT_VLD}} & gnt_q;
        RX_DATA    = rx_on ? M_DOUT : 8'h00;
        GNT        = gnt_q;
        DONE       = done_q;
        BUSY       = state_q != IDLE;
        M_ADDR     = addr_q;
        state_d    = state_q;
        gnt_d      = gnt_q;
        g_d        = g_q;
        last_d     = last_q;
        addr_d     = addr_q;
        len_d      = len_q;
        tx_cnt_d   = tx_cnt_q + LEN_W'(tx_acc);
        rx_cnt_d   = rx_cnt_q + LEN_W'(rx_on & M_DOUT_VLD);
        case (state_q)
            IDLE: if (|REQ) begin
                state_d  = XFER;
                g_d      = win;
                gnt_d    = win ? 2'b10 : 2'b01;
                addr_d   = win ? ADDR_IN[2*ADDR_W-1:ADDR_W] : ADDR_IN[ADDR_W-1:0];
                len_d    = win ? LEN_IN[2*LEN_W-1:LEN_W] : LEN_IN[LEN_W-1:0];
                tx_cnt_d = '0;
                rx_cnt_d = '0;
            end
            // a final DOUT landing with the final TX accept skips DRAIN
            XFER:  if (tx_acc && tx_last) state_d = rx_last ? FIN : DRAIN;
            DRAIN: if (rx_last) state_d = FIN;
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                last_d  = g_q;
            end
        endcase
        done_d = (state_d == FIN) ? gnt_q : 2'b00;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            g_q      <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            len_q    <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            g_q      <= g_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end
endmodule
